i2c_bus_arbiter: RTL and testbench

Shares one I2C master between NUM_REQ requester controllers, such as the MPU6050 controller and future sensor controllers. It grants the bus round-robin and holds the grant for a whole multi-step transaction (address write, data write, repeated read). It muxes each requester's command fields onto the master and routes master status back to the granted requester only. A watchdog forcibly releases a requester that stalls the bus.

---
 rtl/i2c_pkg.sv | 14 +
 rtl/rr_arbiter_pick.sv | 31 +++
 rtl/i2c_bus_arbiter.sv | 174 +++++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C field widths and bus-arbiter state encoding.
package i2c_pkg;

    localparam int I2C_ADDR_W   = 7;
    localparam int I2C_NBYTES_W = 6;
    localparam int I2C_DATA_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
module rr_arbiter_pick #(
    parameter int N     = 2,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     winner,
    output logic             valid
);

    logic [PTR_W-1:0] scan_idx;
    logic             found;

    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = ptr;
        // Offset N lands back on ptr itself, so it only wins when alone.
        for (int off = 1; off <= N; off++) begin
            scan_idx = PTR_W'((int'(ptr) + off) % N);
            if (!found && req[scan_idx]) begin
                winner[scan_idx] = 1'b1;
                found            = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin sharer of one I2C master between NUM_REQ controllers, with a
// watchdog that forcibly releases a requester that stalls the bus.
module i2c_bus_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 960000
) (
    input  logic                           clk_in,
    input  logic                           n_rst,
    input  logic [NUM_REQ-1:0]             req_in,
    output logic [NUM_REQ-1:0]             gnt_out,
    input  logic [NUM_REQ-1:0]             req_en_in,
    input  logic [NUM_REQ-1:0]             req_rd_wr_in,
    input  logic [NUM_REQ-1:0]             req_continuous_in,
    input  logic [I2C_ADDR_W*NUM_REQ-1:0]  req_address_in,
    input  logic [I2C_NBYTES_W*NUM_REQ-1:0] req_data_bytes_in,
    input  logic [I2C_DATA_W*NUM_REQ-1:0]  req_wr_data_in,
    output logic [NUM_REQ-1:0]             req_ready_out,
    output logic [NUM_REQ-1:0]             req_wr_valid_out,
    output logic [NUM_REQ-1:0]             req_rd_valid_out,
    output logic [I2C_DATA_W-1:0]          req_rd_data_out,
    input  logic                           i2c_ready_in,
    input  logic                           i2c_wr_valid_in,
    input  logic                           i2c_rd_valid_in,
    input  logic [I2C_DATA_W-1:0]          i2c_rd_data_in,
    output logic                           i2c_en,
    output logic                           i2c_rd_wr,
    output logic                           i2c_continuous,
    output logic [I2C_ADDR_W-1:0]          i2c_address,
    output logic [I2C_NBYTES_W-1:0]        i2c_data_bytes,
    output logic [I2C_DATA_W-1:0]          i2c_wr_data,
    output logic                           timeout_out
);

    localparam int               IDX_W    = $clog2(NUM_REQ);
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   g_idx_q, g_idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic               timeout_q, timeout_d;

    logic [NUM_REQ-1:0] pick_onehot;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic               in_grant;
    logic               strobe;
    logic               release_req;
    logic               wd_expired;

    rr_arbiter_pick #(
        .N     (NUM_REQ),
        .PTR_W (IDX_W)
    ) u_pick (
        .req    (req_in),
        .ptr    (ptr_q),
        .winner (pick_onehot),
        .valid  (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_onehot[k]) pick_idx = IDX_W'(k);
        end
    end

    assign in_grant    = (state_q == GRANT);
    assign strobe      = i2c_wr_valid_in | i2c_rd_valid_in;
    assign release_req = in_grant && !req_in[g_idx_q] && i2c_ready_in && !req_en_in[g_idx_q];
    // A clean release in the expiry cycle takes priority over the forced one.
    assign wd_expired  = in_grant && (wd_cnt_q == CNT_LAST) && !strobe && !release_req;

    always_ff @(posedge clk_in or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            g_idx_q   <= '0;
            ptr_q     <= IDX_W'(NUM_REQ - 1);
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            g_idx_q   <= g_idx_d;
            ptr_q     <= ptr_d;
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        g_idx_d   = g_idx_q;
        ptr_d     = ptr_q;
        wd_cnt_d  = wd_cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                wd_cnt_d = '0;
                if (i2c_ready_in && pick_valid) begin
                    state_d = GRANT;
                    gnt_d   = pick_onehot;
                    g_idx_d = pick_idx;
                end
            end
            GRANT: begin
                if (release_req) begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    ptr_d    = g_idx_q;
                    wd_cnt_d = '0;
                end else if (wd_expired) begin
                    state_d   = DRAIN;
                    gnt_d     = '0;
                    ptr_d     = g_idx_q;
                    wd_cnt_d  = '0;
                    timeout_d = 1'b1;
                end else if (strobe) begin
                    wd_cnt_d = '0;
                end else if (wd_cnt_q != CNT_LAST) begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                wd_cnt_d = '0;
                if (i2c_ready_in) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        i2c_en         = 1'b0;
        i2c_rd_wr      = 1'b0;
        i2c_continuous = 1'b0;
        i2c_address    = '0;
        i2c_data_bytes = '0;
        i2c_wr_data    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (in_grant && (g_idx_q == IDX_W'(k))) begin
                i2c_en         = req_en_in[k] & ~wd_expired;
                i2c_rd_wr      = req_rd_wr_in[k];
                i2c_continuous = req_continuous_in[k];
                i2c_address    = req_address_in[k*I2C_ADDR_W +: I2C_ADDR_W];
                i2c_data_bytes = req_data_bytes_in[k*I2C_NBYTES_W +: I2C_NBYTES_W];
                i2c_wr_data    = req_wr_data_in[k*I2C_DATA_W +: I2C_DATA_W];
            end
        end
    end

    // gnt_q is zero outside GRANT, so it doubles as the status-path enable.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_status
            assign req_ready_out[gi]    = gnt_q[gi] & i2c_ready_in;
            assign req_wr_valid_out[gi] = gnt_q[gi] & i2c_wr_valid_in;
            assign req_rd_valid_out[gi] = gnt_q[gi] & i2c_rd_valid_in;
        end
    endgenerate

    assign req_rd_data_out = in_grant ? i2c_rd_data_in : '0;
    assign gnt_out         = gnt_q;
    assign timeout_out     = timeout_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Scoreboarded bench for i2c_bus_arbiter: grant/timeout/strobe events checked
// in order by a monitor, level checks made directly by the stimulus.
module tb_i2c_bus_arbiter;

    localparam int NR = 2;
    localparam int TO = 16;

    localparam logic [1:0] EV_GNT = 2'd0;
    localparam logic [1:0] EV_TO  = 2'd1;
    localparam logic [1:0] EV_RD  = 2'd2;
    localparam logic [1:0] EV_WR  = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] data;
    } evt_t;

    logic          clk_in = 1'b0;
    logic          n_rst;
    logic [NR-1:0] req_in, gnt_out, req_en_in, req_rd_wr_in, req_continuous_in;
    logic [7*NR-1:0] req_address_in;
    logic [6*NR-1:0] req_data_bytes_in;
    logic [8*NR-1:0] req_wr_data_in;
    logic [NR-1:0] req_ready_out, req_wr_valid_out, req_rd_valid_out;
    logic [7:0]    req_rd_data_out;
    logic          i2c_ready_in, i2c_wr_valid_in, i2c_rd_valid_in;
    logic [7:0]    i2c_rd_data_in;
    logic          i2c_en, i2c_rd_wr, i2c_continuous;
    logic [6:0]    i2c_address;
    logic [5:0]    i2c_data_bytes;
    logic [7:0]    i2c_wr_data;
    logic          timeout_out;

    evt_t          exp_q[$];
    int            tests = 0;
    int            fails = 0;
    logic [NR-1:0] prev_gnt = '0;
    logic [7:0]    rd_vec [6] = '{8'h3A, 8'hC5, 8'h00, 8'hFF, 8'h81, 8'h7E};

    always #5 clk_in = ~clk_in;

    i2c_bus_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
        .clk_in            (clk_in),
        .n_rst             (n_rst),
        .req_in            (req_in),
        .gnt_out           (gnt_out),
        .req_en_in         (req_en_in),
        .req_rd_wr_in      (req_rd_wr_in),
        .req_continuous_in (req_continuous_in),
        .req_address_in    (req_address_in),
        .req_data_bytes_in (req_data_bytes_in),
        .req_wr_data_in    (req_wr_data_in),
        .req_ready_out     (req_ready_out),
        .req_wr_valid_out  (req_wr_valid_out),
        .req_rd_valid_out  (req_rd_valid_out),
        .req_rd_data_out   (req_rd_data_out),
        .i2c_ready_in      (i2c_ready_in),
        .i2c_wr_valid_in   (i2c_wr_valid_in),
        .i2c_rd_valid_in   (i2c_rd_valid_in),
        .i2c_rd_data_in    (i2c_rd_data_in),
        .i2c_en            (i2c_en),
        .i2c_rd_wr         (i2c_rd_wr),
        .i2c_continuous    (i2c_continuous),
        .i2c_address       (i2c_address),
        .i2c_data_bytes    (i2c_data_bytes),
        .i2c_wr_data       (i2c_wr_data),
        .timeout_out       (timeout_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic push_ev(input logic [1:0] kind, input logic [15:0] data);
        evt_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [1:0] kind, input logic [15:0] data);
        evt_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: got kind %0d data %0h, expected nothing (t=%0t)", kind, data, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.data !== data) begin
                fails++;
                $display("FAIL sb_event: got kind %0d data %0h expected kind %0d data %0h (t=%0t)",
                         kind, data, e.kind, e.data, $time);
            end else begin
                $display("ok   sb_event kind %0d data %0h", kind, data);
            end
        end
    endtask

    // Monitor: every output event pops one expectation, in a fixed per-cycle order.
    initial begin
        forever begin
            @(negedge clk_in);
            if (gnt_out !== prev_gnt) begin
                sb_pop(EV_GNT, 16'(gnt_out));
                prev_gnt = gnt_out;
            end
            if (timeout_out === 1'b1) sb_pop(EV_TO, 16'd1);
            if (|req_rd_valid_out) sb_pop(EV_RD, {8'(req_rd_valid_out), req_rd_data_out});
            if (|req_wr_valid_out) sb_pop(EV_WR, 16'(req_wr_valid_out));
        end
    end

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_in);
    endtask

    function automatic logic [NR-1:0] oh(input int g);
        logic [NR-1:0] one;
        one = 1;
        return one << g;
    endfunction

    // Entered at the negedge of the first GRANT cycle of requester g; leaves at
    // the negedge of the first GRANT cycle of the next winner.
    task automatic write_txn(input int g, input logic [NR-1:0] next_gnt);
        logic [7:0] exp_wd;
        exp_wd = (g == 0) ? 8'hA5 : 8'h5A;
        cyc(); req_en_in[g] = 1'b1;
        mid();
        chk("txn_en", 32'(i2c_en), 32'd1);
        chk("txn_wdata", 32'(i2c_wr_data), 32'(exp_wd));
        chk("txn_rdwr", 32'(i2c_rd_wr), 32'(g));
        cyc(); req_en_in[g] = 1'b0; i2c_ready_in = 1'b0;
        mid();
        chk("txn_busy_ready", 32'(req_ready_out), 32'd0);
        repeat (2) begin
            cyc(); i2c_wr_valid_in = 1'b1; push_ev(EV_WR, 16'(oh(g)));
            cyc(); i2c_wr_valid_in = 1'b0;
        end
        cyc(); i2c_ready_in = 1'b1; req_in[g] = 1'b0; push_ev(EV_GNT, 16'd0);
        mid();
        chk("txn_hold", 32'(gnt_out), 32'(oh(g)));
        cyc(); req_in[g] = 1'b1; push_ev(EV_GNT, 16'(next_gnt));
        mid();
        chk("txn_turnaround", 32'(gnt_out), 32'd0);
        cyc();
        mid();
        chk("txn_regrant", 32'(gnt_out), 32'(next_gnt));
    endtask

    initial begin
        n_rst = 1'b0;
        req_in = '0; req_en_in = '0; req_rd_wr_in = 2'b10; req_continuous_in = '0;
        req_address_in    = {7'h3C, 7'h68};
        req_data_bytes_in = {6'd6, 6'd2};
        req_wr_data_in    = {8'h5A, 8'hA5};
        i2c_ready_in = 1'b1; i2c_wr_valid_in = 1'b0; i2c_rd_valid_in = 1'b0; i2c_rd_data_in = '0;

        // Reset held with everything requesting.
        cyc(); req_in = 2'b11; req_en_in = 2'b11;
        mid();
        chk("reset_gnt", 32'(gnt_out), 32'd0);
        chk("reset_en", 32'(i2c_en), 32'd0);
        chk("reset_addr", 32'(i2c_address), 32'd0);
        chk("reset_timeout", 32'(timeout_out), 32'd0);
        chk("reset_ready", 32'(req_ready_out), 32'd0);
        cyc(); req_in = '0; req_en_in = '0; n_rst = 1'b1;
        cyc();
        mid();
        chk("idle_gnt", 32'(gnt_out), 32'd0);

        // Single requester 0.
        cyc(); req_in = 2'b01; push_ev(EV_GNT, 16'h1);
        mid();
        chk("gnt_latency", 32'(gnt_out), 32'd0);
        cyc();
        mid();
        chk("t1_gnt", 32'(gnt_out), 32'h1);
        chk("t1_addr", 32'(i2c_address), 32'h68);
        chk("t1_ready", 32'(req_ready_out), 32'h1);
        chk("t1_nbytes", 32'(i2c_data_bytes), 32'd2);

        // Both requesting: alternation 01,10,01,10.
        req_in = 2'b11;
        write_txn(0, 2'b10);
        chk("t2_addr1", 32'(i2c_address), 32'h3C);
        write_txn(1, 2'b01);
        write_txn(0, 2'b10);

        // Requester 1 drops req while the master is busy.
        cyc(); req_en_in[1] = 1'b1;
        cyc(); req_en_in[1] = 1'b0; i2c_ready_in = 1'b0; req_in[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("t3_hold", 32'(gnt_out), 32'h2);
            chk("t3_ready0", 32'(req_ready_out), 32'd0);
            cyc();
        end
        i2c_ready_in = 1'b1; push_ev(EV_GNT, 16'd0);
        mid();
        chk("t3_ready_fwd", 32'(req_ready_out), 32'h2);
        cyc(); push_ev(EV_GNT, 16'h1);
        mid();
        chk("t3_released", 32'(gnt_out), 32'd0);
        cyc();
        mid();
        chk("t3_next", 32'(gnt_out), 32'h1);

        // Six-byte continuous read on requester 0.
        req_rd_wr_in[0] = 1'b1; req_continuous_in[0] = 1'b1; req_data_bytes_in[5:0] = 6'd6;
        cyc(); req_en_in[0] = 1'b1;
        mid();
        chk("t4_cont", 32'(i2c_continuous), 32'd1);
        chk("t4_nbytes", 32'(i2c_data_bytes), 32'd6);
        chk("t4_rdwr", 32'(i2c_rd_wr), 32'd1);
        cyc(); req_en_in[0] = 1'b0; i2c_ready_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(); i2c_rd_valid_in = 1'b1; i2c_rd_data_in = rd_vec[i];
            push_ev(EV_RD, {8'h01, rd_vec[i]});
            cyc(); i2c_rd_valid_in = 1'b0; i2c_rd_data_in = 8'h00;
        end
        cyc(); i2c_ready_in = 1'b1; req_in[0] = 1'b0; push_ev(EV_GNT, 16'd0);
        cyc();
        mid();
        chk("t4_idle", 32'(gnt_out), 32'd0);

        // Watchdog: requester 1 wins (pointer at 0) and stalls.
        cyc(); req_in = 2'b11; push_ev(EV_GNT, 16'h2);
        cyc(); req_en_in[1] = 1'b1;
        mid();
        chk("t5_gnt", 32'(gnt_out), 32'h2);
        cyc(); i2c_ready_in = 1'b0;
        repeat (13) cyc();
        mid();
        chk("t5_en_live", 32'(i2c_en), 32'd1);
        chk("t5_gnt_live", 32'(gnt_out), 32'h2);
        cyc();
        mid();
        chk("t5_to_early", 32'(timeout_out), 32'd0);
        cyc(); push_ev(EV_GNT, 16'd0); push_ev(EV_TO, 16'd1);
        mid();
        chk("t5_timeout", 32'(timeout_out), 32'd1);
        chk("t5_en_forced", 32'(i2c_en), 32'd0);
        chk("t5_gnt_clr", 32'(gnt_out), 32'd0);
        cyc();
        mid();
        chk("t5_pulse_end", 32'(timeout_out), 32'd0);
        cyc(); cyc();
        mid();
        chk("t5_drain", 32'(gnt_out), 32'd0);
        cyc(); i2c_ready_in = 1'b1;
        mid();
        chk("t5_drain_exit", 32'(gnt_out), 32'd0);
        cyc(); push_ev(EV_GNT, 16'h1);
        mid();
        chk("t5_idle", 32'(gnt_out), 32'd0);
        cyc();
        mid();
        chk("t5_other", 32'(gnt_out), 32'h1);

        // Requester 0 releases at once so the pointer sits at 0, then reset during 1's grant.
        req_in[0] = 1'b0; req_en_in[0] = 1'b0; push_ev(EV_GNT, 16'd0);
        cyc(); req_in[0] = 1'b1; push_ev(EV_GNT, 16'h2);
        mid();
        chk("t6_idle", 32'(gnt_out), 32'd0);
        cyc();
        mid();
        chk("t6_gnt1", 32'(gnt_out), 32'h2);
        chk("t6_en", 32'(i2c_en), 32'd1);
        cyc(); push_ev(EV_GNT, 16'd0);
        #2 n_rst = 1'b0;
        #1;
        chk("t6_rst_en", 32'(i2c_en), 32'd0);
        chk("t6_rst_gnt", 32'(gnt_out), 32'd0);
        cyc(); cyc(); n_rst = 1'b1; push_ev(EV_GNT, 16'h1);
        mid();
        chk("t6_post_rst", 32'(gnt_out), 32'd0);
        cyc();
        mid();
        chk("t6_first", 32'(gnt_out), 32'h1);

        // Wind down.
        req_in = '0; req_en_in = '0; push_ev(EV_GNT, 16'd0);
        cyc(); cyc(); cyc();
        mid();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
